// File: rtl/pll_lock_detect_pkg.sv
// Shared types and default constants for the Canary PLL digital lock detector.
package pll_lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    ACQUIRE = 2'd2,
    LOCKED  = 2'd3
  } lock_state_t;

  localparam int DEF_CNT_W        = 10;
  localparam int DEF_DIVN_W       = 8;
  localparam int DEF_TOL          = 1;
  localparam int DEF_LOCK_COUNT   = 16;
  localparam int DEF_UNLOCK_COUNT = 2;

  localparam int unsigned CNT_MAX = (32'd1 << DEF_CNT_W) - 32'd1;

endpackage

// File: rtl/pll_lock_detect_if.sv
// Control/status bundle between the lock detector and its consumer.
interface pll_lock_detect_if
  import pll_lock_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int DIVN_W = DEF_DIVN_W
);
  logic              enable;
  logic              refclk;
  logic [DIVN_W-1:0] divn;
  logic              locked;
  logic [CNT_W-1:0]  period;
  logic              period_valid;
  logic              unlock_pulse;

  modport master (
    output enable, refclk, divn,
    input  locked, period, period_valid, unlock_pulse
  );

  modport slave (
    input  enable, refclk, divn,
    output locked, period, period_valid, unlock_pulse
  );
endinterface

// File: rtl/pll_lock_detect_sync_rise.sv
// Multi-flop synchronizer for an asynchronous level, followed by a registered
// rising-edge pulse.
module sync_rise #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic [STAGES-1:0] sync;
  logic              prev;

  // Synchronizer chain, edge-history flop and registered rise pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
    end
  end
endmodule

// File: rtl/pll_lock_detect.sv
// Lock detector: measures pclk cycles per reference period and tracks lock
// with acquire/unlock hysteresis and loss-of-reference detection.
module pll_lock_detect
  import pll_lock_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DIVN_W       = DEF_DIVN_W,
  parameter int TOL          = DEF_TOL,
  parameter int LOCK_COUNT   = DEF_LOCK_COUNT,
  parameter int UNLOCK_COUNT = DEF_UNLOCK_COUNT
) (
  input  logic             clock,
  input  logic             reset,
  pll_lock_detect_if.slave bus
);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] SAT_VAL = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  lock_state_t       state;
  logic              ref_rise;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic [BAD_W-1:0]  bad_cnt;
  logic [DIVN_W-1:0] divn;
  logic              sat;
  logic              match;
  logic [CNT_W:0]    cnt_ext;
  logic [CNT_W:0]    divn_ext;
  logic [CNT_W:0]    diff;

  assign divn = bus.divn;

  sync_rise #(.STAGES(2)) u_ref_sync (
    .clock (clock),
    .reset (reset),
    .din   (bus.refclk),
    .rise  (ref_rise)
  );

  // Saturation flag and tolerance comparator (one bit wider so the difference never wraps)
  always_comb begin
    sat      = (cnt == SAT_VAL);
    cnt_ext  = {1'b0, cnt};
    divn_ext = (CNT_W+1)'(divn);
    if (cnt_ext >= divn_ext) begin
      diff = cnt_ext - divn_ext;
    end else begin
      diff = divn_ext - cnt_ext;
    end
    match = !sat && (divn != '0) && (diff <= (CNT_W+1)'(TOL));
  end

  // Period counter: restarts on every reference edge, saturates on reference loss
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!bus.enable || state == IDLE) begin
      cnt <= '0;
    end else if (ref_rise) begin
      cnt <= CNT_ONE;
    end else if (state == ARM || sat) begin
      cnt <= cnt;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Lock FSM with hysteresis counters and registered status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      good_cnt         <= '0;
      bad_cnt          <= '0;
      bus.locked       <= 1'b0;
      bus.period       <= '0;
      bus.period_valid <= 1'b0;
      bus.unlock_pulse <= 1'b0;
    end else begin
      bus.period_valid <= 1'b0;
      bus.unlock_pulse <= 1'b0;
      if (!bus.enable) begin
        state      <= IDLE;
        good_cnt   <= '0;
        bad_cnt    <= '0;
        bus.locked <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (ref_rise) state <= ACQUIRE;
          end
          ACQUIRE: begin
            if (ref_rise) begin
              bus.period       <= cnt;
              bus.period_valid <= 1'b1;
              if (!match) begin
                good_cnt <= '0;
              end else if (good_cnt == GOOD_W'(LOCK_COUNT - 1)) begin
                state      <= LOCKED;
                bus.locked <= 1'b1;
                good_cnt   <= '0;
                bad_cnt    <= '0;
              end else begin
                good_cnt <= good_cnt + {{(GOOD_W-1){1'b0}}, 1'b1};
              end
            end
          end
          LOCKED: begin
            // A reference edge coincident with saturation is measured, not treated as loss
            if (ref_rise) begin
              bus.period       <= cnt;
              bus.period_valid <= 1'b1;
              if (match) begin
                bad_cnt <= '0;
              end else if (bad_cnt == BAD_W'(UNLOCK_COUNT - 1)) begin
                state            <= ACQUIRE;
                bus.locked       <= 1'b0;
                bus.unlock_pulse <= 1'b1;
                good_cnt         <= '0;
                bad_cnt          <= '0;
              end else begin
                bad_cnt <= bad_cnt + {{(BAD_W-1){1'b0}}, 1'b1};
              end
            end else if (sat) begin
              state            <= ACQUIRE;
              bus.locked       <= 1'b0;
              bus.unlock_pulse <= 1'b1;
              good_cnt         <= '0;
              bad_cnt          <= '0;
            end
          end
          default: begin
            state      <= IDLE;
            bus.locked <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pll_lock_detect.sv
// Randomized scoreboard bench for pll_lock_detect with a period-level lock model.
module tb_pll_lock_detect;
  localparam int CNT_W  = 10;
  localparam int DIVN_W = 8;
  localparam int MAXP   = 1023;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pll_lock_detect_if #(.CNT_W(CNT_W), .DIVN_W(DIVN_W)) bus ();

  pll_lock_detect #(
    .CNT_W(CNT_W), .DIVN_W(DIVN_W), .TOL(1), .LOCK_COUNT(16), .UNLOCK_COUNT(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit loss;
    int per;
    bit lk;
    bit up;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pv_seen  = 0;
  bit   locked_seen = 1'b0;

  // reference model: one entry per reference edge, in whole clock periods
  bit m_armed  = 1'b0;
  bit m_locked = 1'b0;
  int m_good   = 0;
  int m_bad    = 0;
  int m_gap    = 0;
  int m_last_period = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_armed  = 1'b0;
    m_locked = 1'b0;
    m_good   = 0;
    m_bad    = 0;
  endtask

  task automatic model_rise(int next_gap);
    int per;
    int dd;
    bit match;
    bit up;
    if (!m_armed) begin
      m_armed = 1'b1;
    end else begin
      per = (m_gap > MAXP) ? MAXP : m_gap;
      dd  = m_gap - int'(bus.divn);
      if (dd < 0) dd = -dd;
      match = (m_gap < MAXP) && (bus.divn != '0) && (dd <= 1);
      up = 1'b0;
      if (!m_locked) begin
        m_good = match ? m_good + 1 : 0;
        if (m_good == 16) begin
          m_locked = 1'b1;
          m_good = 0;
          m_bad  = 0;
        end
      end else begin
        m_bad = match ? 0 : m_bad + 1;
        if (m_bad == 2) begin
          m_locked = 1'b0;
          up = 1'b1;
          m_good = 0;
          m_bad  = 0;
        end
      end
      sb.push_back('{loss: 1'b0, per: per, lk: m_locked, up: up});
      m_last_period = per;
    end
    // reference silent for longer than the counter range while locked
    if (m_locked && next_gap > MAXP) begin
      m_locked = 1'b0;
      m_good = 0;
      m_bad  = 0;
      sb.push_back('{loss: 1'b1, per: 0, lk: 1'b0, up: 1'b1});
    end
    m_gap = next_gap;
  endtask

  // one reference period of n clocks, rising edge first
  task automatic ref_period(int n, int d);
    @(posedge clock);
    #1;
    bus.divn   = DIVN_W'(d);
    bus.refclk = 1'b1;
    model_rise(n);
    repeat (n / 2) @(posedge clock);
    #1 bus.refclk = 1'b0;
    repeat (n - n / 2 - 1) @(posedge clock);
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_locked"}, int'(bus.locked), 0);
    check({tag, "_period"}, int'(bus.period), 0);
    check({tag, "_period_valid"}, int'(bus.period_valid), 0);
    check({tag, "_unlock_pulse"}, int'(bus.unlock_pulse), 0);
  endtask

  // monitor: every output event is matched against the scoreboard
  always @(negedge clock) begin
    exp_t e;
    if (bus.locked) locked_seen = 1'b1;
    if (!reset && (bus.period_valid || bus.unlock_pulse)) begin
      if (bus.period_valid) pv_seen++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got period_valid=%0d unlock_pulse=%0d, expected no event (t=%0t)",
                 bus.period_valid, bus.unlock_pulse, $time);
      end else begin
        e = sb.pop_front();
        check("event_kind_period_valid", int'(bus.period_valid), e.loss ? 0 : 1);
        if (!e.loss) check("period", int'(bus.period), e.per);
        check("locked", int'(bus.locked), int'(e.lk));
        check("unlock_pulse", int'(bus.unlock_pulse), int'(e.up));
      end
    end
  end

  initial begin
    int d;
    int g;
    int pv_before;
    bus.enable = 1'b0;
    bus.refclk = 1'b0;
    bus.divn   = '0;

    repeat (3) @(posedge clock);
    #1 check_outputs_zero("in_reset");
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 check_outputs_zero("after_reset");

    // invalid divn: measurements appear but never lock
    bus.enable = 1'b1;
    repeat (2) @(posedge clock);
    pv_before = pv_seen;
    ref_period(30, 0);
    check("arm_edge_no_valid", pv_seen - pv_before, 0);
    locked_seen = 1'b0;
    for (int i = 0; i < 12; i++) ref_period($urandom_range(20, 60), 0);
    check("divn0_valid_count", pv_seen - pv_before, 12);
    check("divn0_never_locked", int'(locked_seen), 0);

    // out of tolerance: 47 against 45
    locked_seen = 1'b0;
    for (int i = 0; i < 100; i++) ref_period(47, 45);
    check("oot_never_locked", int'(locked_seen), 0);

    // clean lock with +-1 jitter
    for (int i = 0; i < 22; i++) ref_period(44 + $urandom_range(0, 2), 45);
    check("clean_locked", int'(bus.locked), int'(m_locked));
    check("clean_locked_abs", int'(bus.locked), 1);

    // unlock hysteresis
    ref_period(48, 45);
    for (int i = 0; i < 3; i++) ref_period(45, 45);
    check("single_miss_keeps_lock", int'(bus.locked), 1);
    ref_period(48, 45);
    ref_period(48, 45);
    for (int i = 0; i < 20; i++) ref_period(45, 45);
    check("relock_after_hyst", int'(bus.locked), 1);

    // reference loss, then restart and relock
    ref_period(1100, 45);
    for (int i = 0; i < 20; i++) ref_period(45, 45);
    check("relock_after_loss", int'(bus.locked), 1);

    // enable falling while locked
    @(posedge clock);
    #1 bus.enable = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("disable_locked", int'(bus.locked), 0);
    check("disable_no_unlock_pulse", int'(bus.unlock_pulse), 0);
    check("disable_period_held", int'(bus.period), m_last_period);
    model_clear();
    repeat (4) @(posedge clock);
    #1 bus.enable = 1'b1;
    repeat (2) @(posedge clock);

    // randomized divn and jitter
    for (int blk = 0; blk < 3; blk++) begin
      d = $urandom_range(20, 200);
      for (int i = 0; i < 25; i++) begin
        g = d + $urandom_range(0, 2) - 1;
        if ($urandom_range(0, 7) == 0) g = d + ($urandom_range(0, 1) ? 3 : -3);
        ref_period(g, d);
      end
    end

    // reset in the middle of acquisition
    @(posedge clock);
    #1 bus.enable = 1'b0;
    model_clear();
    repeat (3) @(posedge clock);
    #1 bus.enable = 1'b1;
    repeat (2) @(posedge clock);
    for (int i = 0; i < 6; i++) ref_period(45, 45);
    check("pre_reset_sb_empty", sb.size(), 0);
    @(posedge clock);
    #3 reset = 1'b1;
    #1 check_outputs_zero("async_reset");
    model_clear();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    pv_before = pv_seen;
    ref_period(45, 45);
    check("post_reset_arm_no_valid", pv_seen - pv_before, 0);
    for (int i = 0; i < 18; i++) ref_period(45, 45);
    check("post_reset_relock", int'(bus.locked), 1);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clock);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pll_lock_detect.md
# pll_lock_detect

Digital lock detector for the Canary PLL. It runs on the PLL output clock and treats the reference clock as an asynchronous data input. It counts output-clock cycles between consecutive reference rising edges and compares each measured period against the programmed feedback divide ratio. It reports lock only after a run of in-tolerance periods and drops lock on consecutive misses or loss of reference. It is the synthesizable, on-chip counterpart of the bench-side edge measurement, and feeds lock status to clock-gating and status logic.

## Interface
- `CNT_W`, 10: period counter width; saturates at 2^CNT_W-1.
- `DIVN_W`, 8: width of `divn`.
- `TOL`, 1: allowed absolute error, in clocks, between the measured period and `divn`.
- `LOCK_COUNT`, 16: consecutive matching periods required to assert `locked`.
- `UNLOCK_COUNT`, 2: consecutive mismatching periods required to drop `locked`.

Ports:
- `clock`, in, 1: PLL output clock (pclk). One clock; all logic is on this edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: synchronous run enable. Low forces IDLE.
- `refclk`, in, 1: reference clock, asynchronous to `clock`. Sampled as data only.
- `divn`, in, DIVN_W: expected clocks per reference period. Value 0 is invalid and never matches.
- `locked`, out, 1: lock status. Registered.
- `period`, out, CNT_W: last measured period. Holds until the next measurement.
- `period_valid`, out, 1: one-cycle pulse when `period` updates.
- `unlock_pulse`, out, 1: one-cycle pulse on the LOCKED→ACQUIRE transition.

## Operation
- **Reference synchronizer:** `refclk` passes through a 2-flop synchronizer plus an edge flop. `ref_rise` is the registered AND of (synced high, previous low).
- **Period counter `cnt`:**
  - Loads 1 on `ref_rise`.
  - Otherwise increments, saturating at max. `sat` is set when `cnt` is at max.
  - Held at 0 in IDLE.
- **Measurement:** on each `ref_rise` in ACQUIRE or LOCKED:
  - `period <= cnt` and `period_valid <= 1`.
  - `match = !sat && divn != 0 && |cnt - divn| <= TOL`.
  - The difference is computed in CNT_W+1 bits, with `divn` zero-extended.
- **FSM states:** IDLE, ARM, ACQUIRE, LOCKED.
  - **IDLE:** entered on reset or `enable` low. Goes to ARM when `enable` is high.
  - **ARM:** the first `ref_rise` starts the counter, produces no measurement, and moves to ACQUIRE.
  - **ACQUIRE:** a match increments `good_cnt`; a mismatch clears it. When `good_cnt` reaches LOCK_COUNT, go to LOCKED and clear `bad_cnt`.
  - **LOCKED:** a match clears `bad_cnt`; a mismatch increments it. When `bad_cnt` reaches UNLOCK_COUNT, go to ACQUIRE, clear `good_cnt` and pulse `unlock_pulse`.
  - **Loss of reference:** if `sat` becomes set while LOCKED, go to ACQUIRE immediately with `unlock_pulse`. No measurement is taken.
- **Changing `divn`:** `divn` may change at any time. It is sampled only at measurement instants. A change while LOCKED simply produces mismatches.
- **`enable` falling:** next cycle the state is IDLE. `locked` is 0 and the counters are cleared. `period` holds its value. No `unlock_pulse` is generated.
- **Reset values:** all outputs are 0, including `period`. State IDLE, counters 0, synchronizer flops 0.

## Timing
- A `refclk` rising edge appears as `ref_rise` 2–3 clocks later, depending on the synchronizer sample point.
- `period` and `period_valid` are registered one cycle after `ref_rise`.
- `locked` rises in the same cycle as the `period_valid` of the LOCK_COUNTth consecutive match.
- `locked` falls in the same cycle as the `period_valid` of the UNLOCK_COUNTth miss. `unlock_pulse` is coincident with that fall.
- On saturation, `locked` falls one cycle after `cnt` reaches max. `unlock_pulse` is coincident.
- `ref_rise` in the same cycle that `sat` sets: the measurement wins, is a mismatch, and `cnt` reloads 1.
- An asynchronous `reset` mid-operation clears everything immediately. The first edge afterwards is an ARM edge with no measurement.
- Steady-state measurement jitter is ±1 clock from synchronization. TOL must be ≥1.

## Structure
- Package `pll_lock_pkg`:
  - state enum `lock_state_t` (IDLE, ARM, ACQUIRE, LOCKED);
  - default parameter constants;
  - `localparam` for counter max.
- Sub-module `sync_rise`: 2-flop synchronizer plus rising-edge pulse, parameterized on stage count, with asynchronous active-high reset. It is instanced once for `refclk`.
- Top module: period counter, comparator, FSM and the good/bad counters. The counter widths are derived via `$clog2`.

## Test plan
1. **Clean lock:** `divn`=45, refclk = 45 clocks, enable at t0.
   - `period`=45 (±1) on every pulse.
   - No pulse on the first edge.
   - `locked`=1 at the 16th `period_valid`.
2. **Out of tolerance:** refclk = 47 clocks, `divn`=45, TOL=1.
   - `period`=47 repeatedly.
   - `locked` stays 0 for 100 periods.
3. **Unlock hysteresis:** from locked, apply one 48-clock period, then 45-clock periods.
   - `locked` stays 1.
   - Then apply two consecutive 48-clock periods: `locked` drops on the second, with a coincident one-cycle `unlock_pulse`.
4. **Reference loss:** from locked, hold `refclk` low.
   - `locked` drops within 1024 clocks, with `unlock_pulse`.
   - Restarting refclk at 45 clocks: relock after 16 matches.
5. **Reset / enable:**
   - Assert `reset` mid-ACQUIRE: all outputs 0 the same cycle. After release, the first edge gives no `period_valid`.
   - Deassert `enable` while locked: `locked`=0 next cycle, no `unlock_pulse`, `period` held.
6. **Invalid divn:** `divn`=0 with any refclk.
   - `period_valid` pulses.
   - `locked` never asserts.
